// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate generator.
// Covers base opcodes, instruction format codes and skid-buffer state encoding.
package imm_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG_32 = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Fetch-side and execute-side valid/ready bundle of the immediate generator.
// slave is the stage's own view; master is the view of whoever drives it.
interface imm_gen_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [XLEN-1:0] out_target;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal, out_target
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal, out_target
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational opcode-to-format classifier and immediate extractor; zero latency,
// no handshake of its own (the enclosing stage registers its result).
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt,
    output logic            illegal
);
    localparam bit RV64 = (XLEN == 64);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        fmt = FMT_NONE;
        case (opcode)
            OP_REG:                              fmt = FMT_R;
            OP_REG_32:                           fmt = RV64 ? FMT_R : FMT_NONE;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = FMT_I;
            OP_IMM_32:                           fmt = RV64 ? FMT_I : FMT_NONE;
            OP_STORE:                            fmt = FMT_S;
            OP_BRANCH:                           fmt = FMT_B;
            OP_LUI, OP_AUIPC:                    fmt = FMT_U;
            OP_JAL:                              fmt = FMT_J;
            default:                             fmt = FMT_NONE;
        endcase
        illegal = (fmt == FMT_NONE);

        imm = '0;
        case (fmt)
            FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: begin
                imm       = {XLEN{instr[31]}};
                imm[31:0] = {instr[31:12], 12'b0};
            end
            FMT_J: imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase

        // Shift-immediates carry an unsigned shamt, not a signed I-immediate.
        if (opcode == OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101))
            imm = RV64 ? {{(XLEN-6){1'b0}}, instr[25:20]} : {{(XLEN-5){1'b0}}, instr[24:20]};
    end
endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator behind a two-entry skid buffer: 1-cycle latency, 1/cycle.
// in_ready depends only on registered state; stalls park one extra word in the skid entry.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    imm_gen_stage_if.slave bus
);
    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fmt_t            fmt;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{instr: '0, pc: '0, imm: '0, fmt: FMT_NONE, illegal: 1'b0};

    state_t          state, state_nxt;
    logic            live;
    logic            accept;
    logic            load_main, load_skid, skid_to_main;
    entry_t          main_q, skid_q, dec_e;
    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (bus.in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign dec_e = '{instr: bus.in_instr, pc: bus.in_pc, imm: dec_imm,
                     fmt: dec_fmt, illegal: dec_illegal};

    // live keeps in_ready low throughout reset and rises on the first edge after release.
    assign bus.in_ready = live && (state != SKID);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nxt = FULL;
                    load_main = 1'b1;
                end
                FULL: begin
                    if (accept && bus.out_ready) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_nxt = SKID;
                        load_skid = 1'b1;
                    end else if (bus.out_ready) begin
                        state_nxt = EMPTY;
                    end
                end
                SKID: if (bus.out_ready) begin
                    state_nxt    = FULL;
                    skid_to_main = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q <= ENTRY_RST;
            skid_q <= ENTRY_RST;
        end else begin
            if (load_main)
                main_q <= dec_e;
            else if (skid_to_main)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= dec_e;
        end
    end

    assign bus.out_valid   = (state != EMPTY);
    assign bus.out_instr   = main_q.instr;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_target  = main_q.pc + main_q.imm;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: 32- and 64-bit instances, directed vectors.
module tb_imm_gen_stage;
    logic clk;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    imm_gen_stage_if #(.XLEN(32)) b32 ();
    imm_gen_stage_if #(.XLEN(64)) b64 ();

    imm_gen_stage #(.XLEN(32)) d32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
    imm_gen_stage #(.XLEN(64)) d64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send32(input logic [31:0] ins, input logic [31:0] pc, input logic [63:0] imm,
                          input logic [2:0] fmt, input logic ill, input logic [63:0] tgt,
                          input bit push, input bit lat);
        exp_t e;
        bit   rdy = 1'b0;
        b32.in_valid = 1'b1;
        b32.in_instr = ins;
        b32.in_pc    = pc;
        for (int n = 0; n < 40 && !rdy; n++) begin
            rdy = b32.in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        b32.in_valid = 1'b0;
        if (!rdy) chk("send32_timeout", 64'd0, 64'd1);
        if (push) begin
            e = '{instr: ins, pc: {32'd0, pc}, imm: imm, tgt: tgt, fmt: fmt, ill: ill,
                  cyc: lat ? cyc : -1};
            q32.push_back(e);
        end
    endtask

    task automatic send64(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] imm,
                          input logic [2:0] fmt, input logic ill, input logic [63:0] tgt);
        exp_t e;
        bit   rdy = 1'b0;
        b64.in_valid = 1'b1;
        b64.in_instr = ins;
        b64.in_pc    = pc;
        for (int n = 0; n < 40 && !rdy; n++) begin
            rdy = b64.in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        b64.in_valid = 1'b0;
        if (!rdy) chk("send64_timeout", 64'd0, 64'd1);
        e = '{instr: ins, pc: pc, imm: imm, tgt: tgt, fmt: fmt, ill: ill, cyc: cyc};
        q64.push_back(e);
    endtask

    // Monitors sample just after the negedge, when out_ready for the coming edge is settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (b32.out_valid === 1'b1 && b32.out_ready === 1'b1) begin
                if (q32.size() == 0) begin
                    chk("mon32_unexpected", {32'd0, b32.out_instr}, 64'd0);
                end else begin
                    e = q32.pop_front();
                    chk("instr32",   {32'd0, b32.out_instr}, {32'd0, e.instr});
                    chk("pc32",      {32'd0, b32.out_pc}, e.pc);
                    chk("imm32",     {32'd0, b32.out_imm}, e.imm);
                    chk("fmt32",     {61'd0, b32.out_fmt}, {61'd0, e.fmt});
                    chk("illegal32", {63'd0, b32.out_illegal}, {63'd0, e.ill});
                    chk("target32",  {32'd0, b32.out_target}, e.tgt);
                    if (e.cyc >= 0) chk("latency32", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (b64.out_valid === 1'b1 && b64.out_ready === 1'b1) begin
                if (q64.size() == 0) begin
                    chk("mon64_unexpected", {32'd0, b64.out_instr}, 64'd0);
                end else begin
                    e = q64.pop_front();
                    chk("instr64",   {32'd0, b64.out_instr}, {32'd0, e.instr});
                    chk("pc64",      b64.out_pc, e.pc);
                    chk("imm64",     b64.out_imm, e.imm);
                    chk("fmt64",     {61'd0, b64.out_fmt}, {61'd0, e.fmt});
                    chk("illegal64", {63'd0, b64.out_illegal}, {63'd0, e.ill});
                    chk("target64",  b64.out_target, e.tgt);
                    chk("latency64", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_pc = '0; b64.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready32",  {63'd0, b32.in_ready}, 64'd0);
        chk("rst_out_valid32", {63'd0, b32.out_valid}, 64'd0);
        chk("rst_instr32",     {32'd0, b32.out_instr}, 64'd0);
        chk("rst_pc32",        {32'd0, b32.out_pc}, 64'd0);
        chk("rst_imm32",       {32'd0, b32.out_imm}, 64'd0);
        chk("rst_target32",    {32'd0, b32.out_target}, 64'd0);
        chk("rst_fmt32",       {61'd0, b32.out_fmt}, 64'd7);
        chk("rst_illegal32",   {63'd0, b32.out_illegal}, 64'd0);
        chk("rst_in_ready64",  {63'd0, b64.in_ready}, 64'd0);
        chk("rst_fmt64",       {61'd0, b64.out_fmt}, 64'd7);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready32", {63'd0, b32.in_ready}, 64'd1);
        chk("post_rst_in_ready64", {63'd0, b64.in_ready}, 64'd1);

        // Decode sweep, back to back with out_ready high.
        send32(32'hFFF00093, 32'h100, 64'hFFFFFFFF, 3'd1, 1'b0, 64'h000000FF, 1, 1);
        send32(32'hFE20AE23, 32'h100, 64'hFFFFFFFC, 3'd2, 1'b0, 64'h000000FC, 1, 1);
        send32(32'hFE000CE3, 32'h100, 64'hFFFFFFF8, 3'd3, 1'b0, 64'h000000F8, 1, 1);
        send32(32'h123452B7, 32'h100, 64'h12345000, 3'd4, 1'b0, 64'h12345100, 1, 1);
        send32(32'h0010006F, 32'h100, 64'h00000800, 3'd5, 1'b0, 64'h00000900, 1, 1);
        send32(32'h01F09093, 32'h100, 64'h0000001F, 3'd1, 1'b0, 64'h0000011F, 1, 1);
        send32(32'h00000033, 32'h100, 64'h00000000, 3'd0, 1'b0, 64'h00000100, 1, 1);
        send32(32'h0000007F, 32'h100, 64'h00000000, 3'd7, 1'b1, 64'h00000100, 1, 1);
        send32(32'h0000003B, 32'h100, 64'h00000000, 3'd7, 1'b1, 64'h00000100, 1, 1);
        repeat (2) @(negedge clk);

        // Back-pressure: two words fill main+skid, the next two wait for release.
        b32.out_ready = 1'b0;
        send32(32'h00100093, 32'h200, 64'd1, 3'd1, 1'b0, 64'h201, 1, 0);
        send32(32'h00200093, 32'h204, 64'd2, 3'd1, 1'b0, 64'h206, 1, 0);
        chk("bp_in_ready_low", {63'd0, b32.in_ready}, 64'd0);
        fork
            begin
                send32(32'h00300093, 32'h208, 64'd3, 3'd1, 1'b0, 64'h20B, 1, 0);
                send32(32'h00400093, 32'h20C, 64'd4, 3'd1, 1'b0, 64'h210, 1, 0);
            end
            begin
                for (int i = 0; i < 2; i++) begin
                    chk("bp_hold_valid",  {63'd0, b32.out_valid}, 64'd1);
                    chk("bp_hold_instr",  {32'd0, b32.out_instr}, 64'h00100093);
                    chk("bp_hold_target", {32'd0, b32.out_target}, 64'h201);
                    @(negedge clk);
                end
                b32.out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        chk("bp_drained", 64'(q32.size()), 64'd0);

        // Flush while in SKID with a word offered: nothing buffered may come out.
        b32.out_ready = 1'b0;
        send32(32'h00500093, 32'h300, 64'd5, 3'd1, 1'b0, 64'h305, 0, 0);
        send32(32'h00600093, 32'h304, 64'd6, 3'd1, 1'b0, 64'h30A, 0, 0);
        chk("pre_flush_in_ready", {63'd0, b32.in_ready}, 64'd0);
        b32.in_valid = 1'b1;
        b32.in_instr = 32'h00700093;
        b32.in_pc    = 32'h308;
        flush        = 1'b1;
        @(negedge clk);
        flush         = 1'b0;
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        chk("flush_out_valid", {63'd0, b32.out_valid}, 64'd0);
        chk("flush_in_ready",  {63'd0, b32.in_ready}, 64'd1);
        send32(32'h00800093, 32'h30C, 64'd8, 3'd1, 1'b0, 64'h314, 1, 1);
        repeat (2) @(negedge clk);

        // 64-bit instance.
        send64(32'h03F09093, 64'h100, 64'h3F, 3'd1, 1'b0, 64'h13F);
        send64(32'h0000003B, 64'h100, 64'h0, 3'd0, 1'b0, 64'h100);
        send64(32'hFFF00093, 64'h100, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 64'hFF);
        send64(32'h0080006F, 64'hFFFFFFFFFFFFFFFC, 64'h8, 3'd5, 1'b0, 64'h4);
        send64(32'h0000007F, 64'h100, 64'h0, 3'd7, 1'b1, 64'h100);
        repeat (3) @(negedge clk);

        chk("q32_empty", 64'(q32.size()), 64'd0);
        chk("q64_empty", 64'(q64.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
